// File: rtl/frame_sequencer.sv
// frame_sequencer: phase controller for the 40x30 debayer + QOI image path.
// Steps one frame through LOAD -> DEBAYER -> ENCODE -> READOUT and drives the
// active-low run enables of the color and qoi engines from their completion
// flags. It also handles host aborts and oversize encoder results, and counts
// completed frames.
// Optional feature: define FRAME_SEQ_TIMEOUT_EN to add a per-phase watchdog on
// the engine-paced phases (DEBAYER, ENCODE).
module frame_sequencer #(
    parameter int WIDTH          = 40,
    parameter int HEIGHT         = 30,
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_req,
    input  logic        color_done,
    input  logic [12:0] qoi_bytes,
    input  logic        spi_done,
    output logic        color_rst_n,
    output logic        qoi_rst_n,
    output logic        readout_en,
    output logic        busy,
    output logic [2:0]  state,
    output logic [12:0] frame_bytes,
    output logic [15:0] frame_count,
    output logic        aborted,
    output logic        error
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_DEBAYER = 3'd2,
        ST_ENCODE  = 3'd3,
        ST_READOUT = 3'd4,
        ST_ERROR   = 3'd5
    } state_t;

    // Largest legal encoder result: worst-case QOI output for the image.
    localparam logic [12:0] MAX_BYTES_C = 13'(WIDTH * HEIGHT * 5);

    state_t      state_r;
    state_t      next_state_s;
    logic        abort_s;
    logic        count_s;
    logic        capture_s;
    logic        timeout_s;

    logic        color_en_s;
    logic        qoi_en_s;
    logic        readout_s;

    logic        color_rst_n_r;
    logic        qoi_rst_n_r;
    logic        readout_en_r;
    logic        busy_r;
    logic        aborted_r;
    logic        error_r;
    logic [12:0] frame_bytes_r;
    logic [15:0] frame_count_r;

`ifdef FRAME_SEQ_TIMEOUT_EN
    localparam logic [11:0] TIMEOUT_LAST_C = 12'(TIMEOUT_CYCLES - 1);

    logic [11:0] phase_cnt_r;

    // Phase watchdog counter: restarts on each state change, counts only in engine-paced phases
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_cnt_r <= 12'd0;
        end else if (next_state_s != state_r) begin
            phase_cnt_r <= 12'd0;
        end else if ((state_r == ST_DEBAYER) || (state_r == ST_ENCODE)) begin
            phase_cnt_r <= phase_cnt_r + 12'd1;
        end else begin
            phase_cnt_r <= phase_cnt_r;
        end
    end

    // Watchdog expiry: the current engine phase has used its full cycle allowance
    always_comb begin
        timeout_s = 1'b0;
        if (((state_r == ST_DEBAYER) || (state_r == ST_ENCODE)) &&
            (phase_cnt_r == TIMEOUT_LAST_C)) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end
`else
    // The watchdog limit has no meaning in this build; tie it off explicitly.
    logic unused_timeout_s;
    assign unused_timeout_s = (TIMEOUT_CYCLES > 0);
    assign timeout_s        = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic with abort, capture and frame-count qualifiers
    always_comb begin
        next_state_s = state_r;
        abort_s      = 1'b0;
        count_s      = 1'b0;
        capture_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (load_req) begin
                    next_state_s = ST_LOAD;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (!load_req) begin
                    next_state_s = ST_DEBAYER;
                end else begin
                    next_state_s = ST_LOAD;
                end
            end
            ST_DEBAYER: begin
                if (load_req) begin
                    next_state_s = ST_LOAD;
                    abort_s      = 1'b1;
                end else if (color_done) begin
                    next_state_s = ST_ENCODE;
                end else if (timeout_s) begin
                    next_state_s = ST_ERROR;
                end else begin
                    next_state_s = ST_DEBAYER;
                end
            end
            ST_ENCODE: begin
                // A host abort takes precedence over a valid encoder result.
                if (load_req) begin
                    next_state_s = ST_LOAD;
                    abort_s      = 1'b1;
                end else if (qoi_bytes > MAX_BYTES_C) begin
                    next_state_s = ST_ERROR;
                end else if (qoi_bytes != 13'd0) begin
                    next_state_s = ST_READOUT;
                    capture_s    = 1'b1;
                end else if (timeout_s) begin
                    next_state_s = ST_ERROR;
                end else begin
                    next_state_s = ST_ENCODE;
                end
            end
            ST_READOUT: begin
                // A readout that finishes in the same cycle as a new load is a completed frame.
                if (spi_done) begin
                    count_s = 1'b1;
                    if (load_req) begin
                        next_state_s = ST_LOAD;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end else if (load_req) begin
                    next_state_s = ST_LOAD;
                    abort_s      = 1'b1;
                end else begin
                    next_state_s = ST_READOUT;
                end
            end
            ST_ERROR: begin
                if (load_req) begin
                    next_state_s = ST_LOAD;
                end else begin
                    next_state_s = ST_ERROR;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from next state so registered enables line up with the state
    always_comb begin
        color_en_s = 1'b0;
        qoi_en_s   = 1'b0;
        readout_s  = 1'b0;
        case (next_state_s)
            ST_DEBAYER: begin
                color_en_s = 1'b1;
                qoi_en_s   = 1'b0;
                readout_s  = 1'b0;
            end
            ST_ENCODE: begin
                color_en_s = 1'b1;
                qoi_en_s   = 1'b1;
                readout_s  = 1'b0;
            end
            ST_READOUT: begin
                color_en_s = 1'b1;
                qoi_en_s   = 1'b1;
                readout_s  = 1'b1;
            end
            default: begin
                color_en_s = 1'b0;
                qoi_en_s   = 1'b0;
                readout_s  = 1'b0;
            end
        endcase
    end

    // Registered control outputs and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            color_rst_n_r <= 1'b0;
            qoi_rst_n_r   <= 1'b0;
            readout_en_r  <= 1'b0;
            busy_r        <= 1'b0;
            aborted_r     <= 1'b0;
            error_r       <= 1'b0;
        end else begin
            color_rst_n_r <= color_en_s;
            qoi_rst_n_r   <= qoi_en_s;
            readout_en_r  <= readout_s;
            busy_r        <= (next_state_s != ST_IDLE);
            aborted_r     <= abort_s;
            error_r       <= (next_state_s == ST_ERROR);
        end
    end

    // Encoded byte count captured on the ENCODE -> READOUT transition
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_bytes_r <= 13'd0;
        end else if (capture_s) begin
            frame_bytes_r <= qoi_bytes;
        end else begin
            frame_bytes_r <= frame_bytes_r;
        end
    end

    // Completed-frame counter, wraps naturally at 16 bits
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count_r <= 16'd0;
        end else if (count_s) begin
            frame_count_r <= frame_count_r + 16'd1;
        end else begin
            frame_count_r <= frame_count_r;
        end
    end

    assign state       = state_r;
    assign color_rst_n = color_rst_n_r;
    assign qoi_rst_n   = qoi_rst_n_r;
    assign readout_en  = readout_en_r;
    assign busy        = busy_r;
    assign aborted     = aborted_r;
    assign error       = error_r;
    assign frame_bytes = frame_bytes_r;
    assign frame_count = frame_count_r;

endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: table-driven directed checks of frame_sequencer plus
// hand-written multi-cycle sequences (nominal timing, reset mid-frame,
// frame counter wrap, watchdog behaviour).
module tb_frame_sequencer;

    localparam int TB_TIMEOUT = 2048;
    localparam int NVEC       = 30;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_req;
    logic        color_done;
    logic [12:0] qoi_bytes;
    logic        spi_done;
    logic        color_rst_n;
    logic        qoi_rst_n;
    logic        readout_en;
    logic        busy;
    logic [2:0]  state;
    logic [12:0] frame_bytes;
    logic [15:0] frame_count;
    logic        aborted;
    logic        error;

    int checks   = 0;
    int failures = 0;

    frame_sequencer #(
        .WIDTH(40),
        .HEIGHT(30),
        .TIMEOUT_CYCLES(TB_TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .load_req(load_req),
        .color_done(color_done),
        .qoi_bytes(qoi_bytes),
        .spi_done(spi_done),
        .color_rst_n(color_rst_n),
        .qoi_rst_n(qoi_rst_n),
        .readout_en(readout_en),
        .busy(busy),
        .state(state),
        .frame_bytes(frame_bytes),
        .frame_count(frame_count),
        .aborted(aborted),
        .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        lr;
        logic        cd;
        logic [12:0] qb;
        logic        sd;
        logic [2:0]  st;
        logic        crn;
        logic        qrn;
        logic        ro;
        logic        ab;
        logic        er;
        logic [15:0] fc;
        logic [12:0] fb;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic lr, input logic cd, input logic [12:0] qb,
                                input logic sd, input logic [2:0] st, input logic crn,
                                input logic qrn, input logic ro, input logic ab,
                                input logic er, input logic [15:0] fc, input logic [12:0] fb);
        vec_t v;
        v.lr = lr; v.cd = cd; v.qb = qb; v.sd = sd;
        v.st = st; v.crn = crn; v.qrn = qrn; v.ro = ro;
        v.ab = ab; v.er = er; v.fc = fc; v.fb = fb;
        return v;
    endfunction

    // {state, color_rst_n, qoi_rst_n, readout_en, busy, aborted, error, frame_count, frame_bytes}
    function automatic logic [37:0] outs_now();
        return {state, color_rst_n, qoi_rst_n, readout_en, busy, aborted, error,
                frame_count, frame_bytes};
    endfunction

    function automatic logic [37:0] outs_exp(input vec_t v);
        return {v.st, v.crn, v.qrn, v.ro, (v.st != 3'd0), v.ab, v.er, v.fc, v.fb};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic lr, input logic cd, input logic [12:0] qb, input logic sd);
        @(negedge clk);
        load_req   = lr;
        color_done = cd;
        qoi_bytes  = qb;
        spi_done   = sd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //               lr    cd    qb        sd    st    crn   qrn   ro    ab    er    fc      fb
        vecs[0]  = mk(1'b1, 1'b0, 13'd0,    1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 13'd0);
        vecs[1]  = mk(1'b1, 1'b0, 13'd0,    1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 13'd0);
        vecs[2]  = mk(1'b0, 1'b0, 13'd0,    1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 13'd0);
        vecs[3]  = mk(1'b0, 1'b0, 13'd0,    1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 13'd0);
        vecs[4]  = mk(1'b0, 1'b1, 13'd0,    1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 13'd0);
        vecs[5]  = mk(1'b0, 1'b1, 13'd0,    1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 13'd0);
        vecs[6]  = mk(1'b0, 1'b1, 13'd812,  1'b0, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 13'd812);
        vecs[7]  = mk(1'b0, 1'b0, 13'd812,  1'b0, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 13'd812);
        vecs[8]  = mk(1'b0, 1'b0, 13'd812,  1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 13'd812);
        vecs[9]  = mk(1'b1, 1'b0, 13'd0,    1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 13'd812);
        vecs[10] = mk(1'b0, 1'b0, 13'd0,    1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 13'd812);
        vecs[11] = mk(1'b0, 1'b1, 13'd0,    1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 13'd812);
        vecs[12] = mk(1'b1, 1'b1, 13'd500,  1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1, 13'd812);
        vecs[13] = mk(1'b1, 1'b0, 13'd0,    1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 13'd812);
        vecs[14] = mk(1'b0, 1'b0, 13'd0,    1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 13'd812);
        vecs[15] = mk(1'b0, 1'b1, 13'd0,    1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 13'd812);
        vecs[16] = mk(1'b0, 1'b0, 13'd6001, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 13'd812);
        vecs[17] = mk(1'b0, 1'b0, 13'd0,    1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 13'd812);
        vecs[18] = mk(1'b1, 1'b0, 13'd0,    1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 13'd812);
        vecs[19] = mk(1'b0, 1'b0, 13'd0,    1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 13'd812);
        vecs[20] = mk(1'b0, 1'b1, 13'd0,    1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 13'd812);
        vecs[21] = mk(1'b0, 1'b1, 13'd6000, 1'b0, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1, 13'd6000);
        vecs[22] = mk(1'b1, 1'b0, 13'd0,    1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 13'd6000);
        vecs[23] = mk(1'b0, 1'b0, 13'd0,    1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 13'd6000);
        vecs[24] = mk(1'b1, 1'b0, 13'd0,    1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2, 13'd6000);
        vecs[25] = mk(1'b0, 1'b0, 13'd0,    1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 13'd6000);
        vecs[26] = mk(1'b0, 1'b1, 13'd0,    1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 13'd6000);
        vecs[27] = mk(1'b0, 1'b0, 13'd1,    1'b0, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd2, 13'd1);
        vecs[28] = mk(1'b1, 1'b0, 13'd0,    1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2, 13'd1);
        vecs[29] = mk(1'b0, 1'b0, 13'd0,    1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2, 13'd1);

        reset      = 1'b1;
        load_req   = 1'b0;
        color_done = 1'b0;
        qoi_bytes  = 13'd0;
        spi_done   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 64'(outs_now()), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].lr, vecs[i].cd, vecs[i].qb, vecs[i].sd);
            chk($sformatf("vec%0d", i), 64'(outs_now()), 64'(outs_exp(vecs[i])));
        end

        // Reset asserted while in READOUT
        step(1'b0, 1'b1, 13'd0, 1'b0);
        step(1'b0, 1'b0, 13'd100, 1'b0);
        chk("pre_reset_readout", 64'({state, readout_en, frame_bytes}), 64'({3'd4, 1'b1, 13'd100}));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_in_readout", 64'(outs_now()), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 1'b0, 13'd0, 1'b0);
        chk("idle_after_reset", 64'(outs_now()), 64'd0);

        // Nominal frame with realistic phase lengths
        repeat (100) step(1'b1, 1'b0, 13'd0, 1'b0);
        chk("nom_load", 64'({state, color_rst_n, busy}), 64'({3'd1, 1'b0, 1'b1}));
        step(1'b0, 1'b0, 13'd0, 1'b0);
        chk("nom_debayer", 64'({state, color_rst_n, qoi_rst_n, readout_en}), 64'({3'd2, 3'b100}));
        repeat (1200) step(1'b0, 1'b0, 13'd0, 1'b0);
        chk("nom_debayer_wait", 64'({state, qoi_rst_n}), 64'({3'd2, 1'b0}));
        step(1'b0, 1'b1, 13'd0, 1'b0);
        chk("nom_encode", 64'({state, color_rst_n, qoi_rst_n, readout_en}), 64'({3'd3, 3'b110}));
        repeat (2) step(1'b0, 1'b1, 13'd0, 1'b0);
        chk("nom_encode_wait", 64'({state, readout_en}), 64'({3'd3, 1'b0}));
        step(1'b0, 1'b1, 13'd812, 1'b0);
        chk("nom_readout", 64'({state, color_rst_n, qoi_rst_n, readout_en, frame_bytes}),
            64'({3'd4, 3'b111, 13'd812}));
        repeat (49) step(1'b0, 1'b0, 13'd812, 1'b0);
        chk("nom_readout_wait", 64'({state, frame_count}), 64'({3'd4, 16'd0}));
        step(1'b0, 1'b0, 13'd812, 1'b1);
        chk("nom_done", 64'(outs_now()), 64'({3'd0, 6'b000000, 16'd1, 13'd812}));

        // Frame counter wrap through the simultaneous spi_done + load_req case
        force dut.frame_count_r = 16'hFFFF;
        step(1'b0, 1'b0, 13'd0, 1'b0);
        release dut.frame_count_r;
        step(1'b0, 1'b0, 13'd0, 1'b0);
        chk("wrap_preset", 64'(frame_count), 64'(16'hFFFF));
        step(1'b1, 1'b0, 13'd0, 1'b0);
        step(1'b0, 1'b0, 13'd0, 1'b0);
        step(1'b0, 1'b1, 13'd0, 1'b0);
        step(1'b0, 1'b0, 13'd20, 1'b0);
        chk("wrap_readout", 64'(state), 64'(3'd4));
        step(1'b1, 1'b0, 13'd0, 1'b1);
        chk("wrap_simul", 64'({state, aborted, frame_count}), 64'({3'd1, 1'b0, 16'd0}));

        // Watchdog behaviour in DEBAYER with color_done held low
        step(1'b0, 1'b0, 13'd0, 1'b0);
        chk("wd_enter", 64'(state), 64'(3'd2));
`ifdef FRAME_SEQ_TIMEOUT_EN
        repeat (TB_TIMEOUT - 1) step(1'b0, 1'b0, 13'd0, 1'b0);
        chk("wd_before", 64'({state, error}), 64'({3'd2, 1'b0}));
        step(1'b0, 1'b0, 13'd0, 1'b0);
        chk("wd_expired", 64'({state, error, color_rst_n}), 64'({3'd5, 1'b1, 1'b0}));
`else
        repeat (10000) step(1'b0, 1'b0, 13'd0, 1'b0);
        chk("wd_none", 64'({state, error, color_rst_n}), 64'({3'd2, 1'b0, 1'b1}));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Top-level phase controller for the 40x30 debayer + QOI image path. Sequences one frame through load (host SPI shift-in), debayer, QOI encode and readout (host SPI shift-out), driving the active-low run enables of the color and qoi engines from their completion flags. Sits between the SPI front end and the integrated core, replacing direct wiring of `reading` to the core reset. Handles host aborts and malformed encoder results, and counts completed frames.

## Interface
Parameters:
- WIDTH, 40, image width in pixels
- HEIGHT, 30, image height in pixels
- TIMEOUT_CYCLES, 2048, per-phase watchdog limit (used only with FRAME_SEQ_TIMEOUT_EN)

Ports:
- clk  in  1  single system clock, all logic on posedge
- reset  in  1  synchronous, active-high
- load_req  in  1  host shifting image in (SPI `reading` level)
- color_done  in  1  debayer engine finished, level
- qoi_bytes  in  13  encoder byte count; 0 = not finished
- spi_done  in  1  readout of all encoded bytes complete, level
- color_rst_n  out  1  active-low run enable to color engine
- qoi_rst_n  out  1  active-low run enable to qoi engine
- readout_en  out  1  permits SPI shift-out
- busy  out  1  state != IDLE
- state  out  3  IDLE=0, LOAD=1, DEBAYER=2, ENCODE=3, READOUT=4, ERROR=5
- frame_bytes  out  13  qoi_bytes captured at ENCODE exit
- frame_count  out  16  completed frames, wraps 0xFFFF->0
- aborted  out  1  one-cycle pulse on host abort
- error  out  1  high while in ERROR

## Operation
- Transitions (evaluated each posedge, reset has priority):
  - IDLE: load_req=1 -> LOAD.
  - LOAD: load_req=0 -> DEBAYER.
  - DEBAYER: color_done=1 -> ENCODE.
  - ENCODE: qoi_bytes in 1..WIDTH*HEIGHT*5 (6000) -> READOUT, frame_bytes <= qoi_bytes; qoi_bytes > 6000 -> ERROR.
  - READOUT: spi_done=1 -> IDLE, frame_count++.
  - ERROR: held until load_req=1 -> LOAD (error clears) or reset.
- Abort: load_req=1 in DEBAYER/ENCODE/READOUT -> LOAD, aborted pulses one cycle, frame_count unchanged.
- Simultaneous: READOUT with spi_done=1 and load_req=1 -> frame counted, go LOAD, no aborted pulse. ENCODE with valid qoi_bytes and load_req=1 -> abort wins.
- Output decode (registered from next state): color_rst_n=1 in DEBAYER, ENCODE, READOUT; qoi_rst_n=1 in ENCODE, READOUT; readout_en=1 in READOUT only. All three 0 in IDLE, LOAD, ERROR.
- frame_bytes holds last captured value; cleared only by reset.

## Timing
- Reset values: state=IDLE, color_rst_n=0, qoi_rst_n=0, readout_en=0, busy=0, frame_bytes=0, frame_count=0, aborted=0, error=0.
- All outputs registered; condition sampled at edge N -> new state and outputs visible after edge N (one-cycle latency).
- color engine run: color_rst_n rises the cycle after load_req falls; engine done takes 1201 cycles, so ENCODE entered ~1202 cycles later.
- qoi_rst_n rises the cycle after color_done sampled high; readout_en rises the cycle after nonzero qoi_bytes sampled.
- Reset mid-frame: next cycle all outputs at reset values, frame_count zeroed, in-flight frame discarded.

## Configuration
- FRAME_SEQ_TIMEOUT_EN defined: 12-bit phase counter cleared on every state change, incremented in DEBAYER and ENCODE; reaching TIMEOUT_CYCLES in either -> ERROR. LOAD and READOUT are host-paced and never time out.
- Undefined: no counter; DEBAYER/ENCODE wait indefinitely; ERROR reachable only via oversize qoi_bytes.

## Test plan
- Nominal: load_req high 100 cycles then low; color_done at +1201; qoi_bytes=812 at +1204; spi_done 50 cycles later -> states 1,2,3,4,0 in order, frame_bytes=812, frame_count=1, enables as decoded.
- Abort: load_req reasserted during ENCODE -> LOAD next cycle, aborted=1 exactly one cycle, qoi_rst_n=0, color_rst_n=0, frame_count unchanged.
- Oversize: qoi_bytes=6001 in ENCODE -> ERROR, error=1, readout_en stays 0; then load_req=1 -> LOAD, error=0.
- Simultaneous: spi_done=1 and load_req=1 same cycle in READOUT -> LOAD, frame_count+1, aborted=0; frame_count preset to 0xFFFF wraps to 0.
- Timeout (FRAME_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16): color_done held 0 in DEBAYER -> ERROR after 16 cycles; without macro remains DEBAYER after 10000 cycles.
- Reset asserted in READOUT -> next cycle all outputs at reset values, state=IDLE.
